// File: rtl/adder_chk_pkg.sv
// rtl/adder_chk_pkg.sv - shared types and constants for the adder stimulus checker
package adder_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_FINISH
    } state_t;

    // Galois right-shift toggle mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    localparam logic [31:0] CORNER0_A = 32'h0000_0000;
    localparam logic [31:0] CORNER0_B = 32'h0000_0000;
    localparam logic [31:0] CORNER1_A = 32'hFFFF_FFFF;
    localparam logic [31:0] CORNER1_B = 32'h0000_0001;
    localparam logic [31:0] CORNER2_A = 32'h7FFF_FFFF;
    localparam logic [31:0] CORNER2_B = 32'h0000_0001;
    localparam logic [31:0] CORNER3_A = 32'h8000_0000;
    localparam logic [31:0] CORNER3_B = 32'h8000_0000;

    localparam logic [15:0] ERR_NONE = 16'hFFFF;

    function automatic logic [31:0] corner_a(input logic [1:0] idx);
        case (idx)
            2'd0:    return CORNER0_A;
            2'd1:    return CORNER1_A;
            2'd2:    return CORNER2_A;
            default: return CORNER3_A;
        endcase
    endfunction

    function automatic logic [31:0] corner_b(input logic [1:0] idx);
        case (idx)
            2'd0:    return CORNER0_B;
            2'd1:    return CORNER1_B;
            2'd2:    return CORNER2_B;
            default: return CORNER3_B;
        endcase
    endfunction

endpackage

// File: rtl/adder_stim_checker_if.sv
// rtl/adder_stim_checker_if.sv - operand/result bus between checker and adder
interface adder_stim_checker_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             OF;

    modport master (output a, output b, input sum, input OF);
    modport slave  (input a, input b, output sum, output OF);
endinterface

// File: rtl/adder_stim_checker_lfsr32.sv
// rtl/adder_stim_checker_lfsr32.sv - 32-bit Galois LFSR with seed reload
module lfsr32
    import adder_chk_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        advance,
    output logic [31:0] value
);

    logic [31:0] stepped;

    // One Galois step: shift right, fold the tap mask in when a one drops out
    always_comb begin
        stepped = value >> 1;
        if (value[0]) begin
            stepped = (value >> 1) ^ LFSR_TAPS;
        end
    end

    // Reload wins over advance so a new run always restarts from the seed
    always_ff @(posedge clk) begin
        if (rst || load) begin
            value <= SEED;
        end else if (advance) begin
            value <= stepped;
        end
    end

endmodule

// File: rtl/adder_stim_checker.sv
// rtl/adder_stim_checker.sv - self-checking operand source for the 32-bit adder
module adder_stim_checker
    import adder_chk_pkg::*;
#(
    parameter int          WIDTH   = 32,
    parameter int          NUM_VEC = 256,
    parameter int          LATENCY = 0,
    parameter logic [31:0] SEED_A  = 32'hACE1_2468,
    parameter logic [31:0] SEED_B  = 32'h1357_BDF0
) (
    input  logic                 refclk,
    input  logic                 rst,
    input  logic                 locked,
    input  logic                 start,
    adder_stim_checker_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 aborted,
    output logic [15:0]          err_count,
    output logic [15:0]          vec_count,
    output logic [15:0]          first_err_idx
);

    localparam int          MSB         = WIDTH - 1;
    localparam logic [15:0] LAST_VEC    = 16'(NUM_VEC - 1);
    localparam logic [15:0] SETTLE_INIT = (LATENCY > 0) ? 16'(LATENCY - 1) : 16'd0;
    localparam state_t      AFTER_LOAD  = (LATENCY > 0) ? ST_SETTLE : ST_CHECK;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_nxt, b_nxt;
    logic             busy_nxt, done_nxt, pass_nxt, aborted_nxt;
    logic [15:0]      err_nxt, vec_nxt, first_nxt;
    logic [15:0]      settle_cnt, settle_nxt;
    logic [15:0]      next_idx;
    logic             lfsr_load, lfsr_adv;
    logic [31:0]      lfsr_a_val, lfsr_b_val;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_of;
    logic             mismatch;

    lfsr32 #(.SEED(SEED_A)) u_lfsr_a (
        .clk     (refclk),
        .rst     (rst),
        .load    (lfsr_load),
        .advance (lfsr_adv),
        .value   (lfsr_a_val)
    );

    lfsr32 #(.SEED(SEED_B)) u_lfsr_b (
        .clk     (refclk),
        .rst     (rst),
        .load    (lfsr_load),
        .advance (lfsr_adv),
        .value   (lfsr_b_val)
    );

    // Expected result and signed overflow of the operands currently on the bus
    always_comb begin
        exp_sum  = bus.a + bus.b;
        exp_of   = (bus.a[MSB] == bus.b[MSB]) && (exp_sum[MSB] != bus.a[MSB]);
        mismatch = (bus.sum != exp_sum) || (bus.OF != exp_of);
        next_idx = vec_count + 16'd1;
    end

    // Next-state and next-value logic for the run sequencer
    always_comb begin
        state_nxt   = state;
        a_nxt       = bus.a;
        b_nxt       = bus.b;
        busy_nxt    = busy;
        done_nxt    = done;
        pass_nxt    = pass;
        aborted_nxt = aborted;
        err_nxt     = err_count;
        vec_nxt     = vec_count;
        first_nxt   = first_err_idx;
        settle_nxt  = settle_cnt;
        lfsr_load   = 1'b0;
        lfsr_adv    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start && locked) begin
                    done_nxt    = 1'b0;
                    pass_nxt    = 1'b0;
                    aborted_nxt = 1'b0;
                    err_nxt     = 16'd0;
                    vec_nxt     = 16'd0;
                    first_nxt   = ERR_NONE;
                    lfsr_load   = 1'b1;
                    a_nxt       = WIDTH'(corner_a(2'd0));
                    b_nxt       = WIDTH'(corner_b(2'd0));
                    busy_nxt    = 1'b1;
                    settle_nxt  = SETTLE_INIT;
                    state_nxt   = AFTER_LOAD;
                end
            end

            ST_SETTLE: begin
                if (!locked) begin
                    busy_nxt    = 1'b0;
                    aborted_nxt = 1'b1;
                    done_nxt    = 1'b0;
                    state_nxt   = ST_IDLE;
                end else if (settle_cnt == 16'd0) begin
                    state_nxt = ST_CHECK;
                end else begin
                    settle_nxt = settle_cnt - 16'd1;
                end
            end

            ST_CHECK: begin
                if (!locked) begin
                    // The compare of this cycle is thrown away on abort
                    busy_nxt    = 1'b0;
                    aborted_nxt = 1'b1;
                    done_nxt    = 1'b0;
                    state_nxt   = ST_IDLE;
                end else begin
                    if (mismatch) begin
                        if (err_count != 16'hFFFF) begin
                            err_nxt = err_count + 16'd1;
                        end
                        if (first_err_idx == ERR_NONE) begin
                            first_nxt = vec_count;
                        end
                    end
                    vec_nxt = next_idx;
                    if (vec_count == LAST_VEC) begin
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        pass_nxt  = (err_nxt == 16'd0);
                        state_nxt = ST_FINISH;
                    end else begin
                        if (next_idx < 16'd4) begin
                            a_nxt = WIDTH'(corner_a(next_idx[1:0]));
                            b_nxt = WIDTH'(corner_b(next_idx[1:0]));
                        end else begin
                            a_nxt    = WIDTH'(lfsr_a_val);
                            b_nxt    = WIDTH'(lfsr_b_val);
                            lfsr_adv = 1'b1;
                        end
                        settle_nxt = SETTLE_INIT;
                        state_nxt  = AFTER_LOAD;
                    end
                end
            end

            ST_FINISH: begin
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset overrides every other event
    always_ff @(posedge refclk) begin
        if (rst) begin
            state         <= ST_IDLE;
            bus.a         <= '0;
            bus.b         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            aborted       <= 1'b0;
            err_count     <= 16'd0;
            vec_count     <= 16'd0;
            first_err_idx <= ERR_NONE;
            settle_cnt    <= 16'd0;
        end else begin
            state         <= state_nxt;
            bus.a         <= a_nxt;
            bus.b         <= b_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            pass          <= pass_nxt;
            aborted       <= aborted_nxt;
            err_count     <= err_nxt;
            vec_count     <= vec_nxt;
            first_err_idx <= first_nxt;
            settle_cnt    <= settle_nxt;
        end
    end

endmodule

// File: tb/tb_adder_stim_checker.sv
// tb/tb_adder_stim_checker.sv - directed and randomized bench for adder_stim_checker
module tb_adder_stim_checker;

    localparam logic [31:0] SEED_A = 32'hACE1_2468;
    localparam logic [31:0] SEED_B = 32'h1357_BDF0;

    logic        refclk;
    logic        rst;
    logic        locked;
    logic        start [3];
    logic        busy [3];
    logic        done [3];
    logic        pass [3];
    logic        aborted [3];
    logic [15:0] err_count [3];
    logic [15:0] vec_count [3];
    logic [15:0] first_err_idx [3];

    int          mode0;
    logic [31:0] corrupt0;
    int          vectors;
    int          miscompares;

    adder_stim_checker_if if0 ();
    adder_stim_checker_if if1 ();
    adder_stim_checker_if if2 ();

    adder_stim_checker #(.NUM_VEC(8), .LATENCY(0)) dut0 (
        .refclk(refclk), .rst(rst), .locked(locked), .start(start[0]), .bus(if0),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .aborted(aborted[0]),
        .err_count(err_count[0]), .vec_count(vec_count[0]), .first_err_idx(first_err_idx[0])
    );

    adder_stim_checker #(.NUM_VEC(5), .LATENCY(2)) dut1 (
        .refclk(refclk), .rst(rst), .locked(locked), .start(start[1]), .bus(if1),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .aborted(aborted[1]),
        .err_count(err_count[1]), .vec_count(vec_count[1]), .first_err_idx(first_err_idx[1])
    );

    adder_stim_checker #(.NUM_VEC(5), .LATENCY(0)) dut2 (
        .refclk(refclk), .rst(rst), .locked(locked), .start(start[2]), .bus(if2),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]), .aborted(aborted[2]),
        .err_count(err_count[2]), .vec_count(vec_count[2]), .first_err_idx(first_err_idx[2])
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    function automatic logic ref_of(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] s;
        s = x + y;
        return (x[31] == y[31]) && (s[31] != x[31]);
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
    endfunction

    // Operand of vector idx: four fixed corners, then successive LFSR states
    function automatic logic [31:0] ref_vec(input int idx, input bit want_a);
        logic [31:0] v;
        case (idx)
            0:       return 32'h0000_0000;
            1:       return want_a ? 32'hFFFF_FFFF : 32'h0000_0001;
            2:       return want_a ? 32'h7FFF_FFFF : 32'h0000_0001;
            3:       return 32'h8000_0000;
            default: begin
                v = want_a ? SEED_A : SEED_B;
                for (int k = 4; k < idx; k++) v = lfsr_step(v);
                return v;
            end
        endcase
    endfunction

    // dut0 adder: ideal, optionally with OF stuck low and sum bits flipped
    assign if0.sum = (if0.a + if0.b) ^ corrupt0;
    assign if0.OF  = (mode0 == 1) ? 1'b0 : ref_of(if0.a, if0.b);

    // dut1/dut2 adder: two-stage registered model
    logic [31:0] p1_s1, p2_s1, p1_s2, p2_s2;
    logic        p1_o1, p2_o1, p1_o2, p2_o2;
    always @(posedge refclk) begin
        p1_s1 <= if1.a + if1.b;
        p1_o1 <= ref_of(if1.a, if1.b);
        p2_s1 <= p1_s1;
        p2_o1 <= p1_o1;
        p1_s2 <= if2.a + if2.b;
        p1_o2 <= ref_of(if2.a, if2.b);
        p2_s2 <= p1_s2;
        p2_o2 <= p1_o2;
    end
    assign if1.sum = p2_s1;
    assign if1.OF  = p2_o1;
    assign if2.sum = p2_s2;
    assign if2.OF  = p2_o2;

    task automatic step();
        @(negedge refclk);
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic chk_reset(input string tag, input int d, input logic [31:0] av, input logic [31:0] bv);
        chk({tag, "_a"}, av, 32'h0);
        chk({tag, "_b"}, bv, 32'h0);
        chk({tag, "_busy"}, 32'(busy[d]), 32'h0);
        chk({tag, "_done"}, 32'(done[d]), 32'h0);
        chk({tag, "_pass"}, 32'(pass[d]), 32'h0);
        chk({tag, "_aborted"}, 32'(aborted[d]), 32'h0);
        chk({tag, "_err"}, 32'(err_count[d]), 32'h0);
        chk({tag, "_vec"}, 32'(vec_count[d]), 32'h0);
        chk({tag, "_first"}, 32'(first_err_idx[d]), 32'hFFFF);
    endtask

    // One dut0 run of 8 vectors, checked cycle by cycle against the reference model
    task automatic run0(input int mode, input int abort_at, input bit rand_fault, input bit poke);
        int          exp_err;
        int          exp_first;
        logic [31:0] va, vb;
        bit          mism;
        exp_err   = 0;
        exp_first = 16'hFFFF;
        mode0     = mode;
        corrupt0  = 32'h0;
        start[0]  = 1'b1;
        step();
        start[0]  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            va = ref_vec(i, 1'b1);
            vb = ref_vec(i, 1'b0);
            chk($sformatf("d0_a[%0d]", i), if0.a, va);
            chk($sformatf("d0_b[%0d]", i), if0.b, vb);
            chk($sformatf("d0_vec[%0d]", i), 32'(vec_count[0]), 32'(i));
            chk($sformatf("d0_busy[%0d]", i), 32'(busy[0]), 32'h1);
            if (i == 0) begin
                chk("d0_done_cleared", 32'(done[0]), 32'h0);
                chk("d0_aborted_cleared", 32'(aborted[0]), 32'h0);
            end
            corrupt0 = (rand_fault && ($urandom_range(0, 2) == 0)) ?
                       (32'h1 << $urandom_range(0, 31)) : 32'h0;
            start[0] = poke && (i == 4);
            if (i == abort_at) begin
                locked = 1'b0;
                step();
                locked   = 1'b1;
                corrupt0 = 32'h0;
                chk("abort_busy", 32'(busy[0]), 32'h0);
                chk("abort_aborted", 32'(aborted[0]), 32'h1);
                chk("abort_done", 32'(done[0]), 32'h0);
                chk("abort_vec", 32'(vec_count[0]), 32'(i));
                chk("abort_err", 32'(err_count[0]), 32'(exp_err));
                step();
                chk("abort_a_hold", if0.a, va);
                chk("abort_b_hold", if0.b, vb);
                chk("abort_sticky", 32'(aborted[0]), 32'h1);
                return;
            end
            mism = (corrupt0 != 32'h0) || (mode == 1 && ref_of(va, vb));
            if (mism) begin
                exp_err++;
                if (exp_first == 16'hFFFF) exp_first = i;
            end
            step();
            start[0] = 1'b0;
        end
        corrupt0 = 32'h0;
        chk("d0_end_busy", 32'(busy[0]), 32'h0);
        chk("d0_end_done", 32'(done[0]), 32'h1);
        chk("d0_end_pass", 32'(pass[0]), 32'(exp_err == 0));
        chk("d0_end_err", 32'(err_count[0]), 32'(exp_err));
        chk("d0_end_vec", 32'(vec_count[0]), 32'd8);
        chk("d0_end_first", 32'(first_err_idx[0]), 32'(exp_first));
        chk("d0_end_aborted", 32'(aborted[0]), 32'h0);
        step();
        chk("d0_done_hold", 32'(done[0]), 32'h1);
        chk("d0_pass_hold", 32'(pass[0]), 32'(exp_err == 0));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        mode0       = 0;
        corrupt0    = 32'h0;
        rst         = 1'b1;
        locked      = 1'b1;
        for (int d = 0; d < 3; d++) start[d] = 1'b0;
        step();
        step();
        chk_reset("rst_d0", 0, if0.a, if0.b);
        rst = 1'b0;
        step();
        chk_reset("idle_d1", 1, if1.a, if1.b);

        // Ideal adder, then OF stuck low (every overflowing vector must miscompare)
        run0(0, -1, 1'b0, 1'b0);
        run0(1, -1, 1'b0, 1'b0);
        chk("of_stuck_first_is_2", 32'(first_err_idx[0]), 32'd2);

        // Random single-bit sum faults, plus a start pulse while busy
        for (int r = 0; r < 6; r++) run0(0, -1, 1'b1, (r == 2));

        // Two-stage adder with matching latency: each vector held 3 cycles
        start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        for (int c = 0; c < 15; c++) begin
            chk($sformatf("d1_busy[%0d]", c), 32'(busy[1]), 32'h1);
            chk($sformatf("d1_a[%0d]", c), if1.a, ref_vec(c / 3, 1'b1));
            chk($sformatf("d1_b[%0d]", c), if1.b, ref_vec(c / 3, 1'b0));
            step();
        end
        chk("d1_end_busy", 32'(busy[1]), 32'h0);
        chk("d1_end_done", 32'(done[1]), 32'h1);
        chk("d1_end_pass", 32'(pass[1]), 32'h1);
        chk("d1_end_err", 32'(err_count[1]), 32'h0);
        chk("d1_end_vec", 32'(vec_count[1]), 32'd5);
        chk("d1_end_first", 32'(first_err_idx[1]), 32'hFFFF);

        // Same adder with zero latency: results lag by two vectors
        start[2] = 1'b1;
        step();
        start[2] = 1'b0;
        for (int c = 0; c < 5; c++) step();
        chk("d2_done", 32'(done[2]), 32'h1);
        chk("d2_pass", 32'(pass[2]), 32'h0);
        chk("d2_err_nonzero", 32'(err_count[2] != 16'd0), 32'h1);
        chk("d2_first", 32'(first_err_idx[2]), 32'd2);

        // Reset during SETTLE clears everything at the next edge
        start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset("rst_settle_d1", 1, if1.a, if1.b);

        // Start while unlocked is ignored
        locked   = 1'b0;
        start[0] = 1'b1;
        start[1] = 1'b1;
        step();
        start[0] = 1'b0;
        start[1] = 1'b0;
        step();
        locked = 1'b1;
        chk("nolock_busy0", 32'(busy[0]), 32'h0);
        chk("nolock_busy1", 32'(busy[1]), 32'h0);
        chk("nolock_vec1", 32'(vec_count[1]), 32'h0);
        step();
        chk("nolock_still_idle", 32'(busy[1]), 32'h0);

        // Loss of lock on vector 3, then a clean rerun from vector 0
        run0(0, 3, 1'b0, 1'b0);
        run0(0, -1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
